// File: rtl/regfile_writeback_pkg.sv
// Shared types and helpers for the register-file write-back arbiter.
package wb_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREGS  = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  // x0 is hardwired to zero, so it never appears as a pending write.
  function automatic logic [NREGS-1:0] onehot_rd(input logic [REG_AW-1:0] rd);
    logic [NREGS-1:0] m;
    m     = '0;
    m[rd] = 1'b1;
    m[0]  = 1'b0;
    return m;
  endfunction
endpackage

// File: rtl/regfile_writeback_if.sv
// Producer handshakes, register-file write port and busy mask of the write-back stage.
interface regfile_writeback_if #(parameter int XLEN = 32);
  import wb_pkg::*;

  logic              alu_valid;
  logic              alu_ready;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0]   alu_data;
  logic              ld_valid;
  logic              ld_ready;
  logic [REG_AW-1:0] ld_rd;
  logic [XLEN-1:0]   ld_data;
  logic              rf_we;
  logic [REG_AW-1:0] rf_rd;
  logic [XLEN-1:0]   rf_wdata;
  logic [NREGS-1:0]  busy_mask;

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    input  alu_ready, ld_ready, rf_we, rf_rd, rf_wdata, busy_mask
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    output alu_ready, ld_ready, rf_we, rf_rd, rf_wdata, busy_mask
  );
endinterface

// File: rtl/regfile_writeback_fifo.sv
// In-order load-result queue; exposes per-entry valid/rd for hazard and busy tracking.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push_i,
  input  wb_req_t                      push_req_i,
  input  logic                         pop_i,
  output logic                         full_o,
  output logic                         empty_o,
  output wb_req_t                      head_o,
  output logic [DEPTH-1:0]             ent_vld_o,
  output logic [DEPTH-1:0][REG_AW-1:0] ent_rd_o
);
  localparam int PW = $clog2(DEPTH);

  wb_req_t          mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0] vld_q, vld_d;

  // Push and pop never target the same slot: push requires not-full, pop requires not-empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    vld_d    = vld_q;
    if (push_i) begin
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_i) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      vld_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      vld_q    <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_req_i;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_rd_o[i] = mem_q[i].rd;
  end

  assign ent_vld_o = vld_q;
  assign full_o    = &vld_q;
  assign empty_o   = ~|vld_q;
  assign head_o    = mem_q[rd_ptr_q];
endmodule

// File: rtl/regfile_writeback.sv
// Merges ALU and queued load results into one registered register-file write per cycle,
// keeping WAW order between the paths and publishing a pending-write mask.
module regfile_writeback
  import wb_pkg::*;
#(
  parameter int XLEN  = wb_pkg::XLEN,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  regfile_writeback_if.slave wb
);
  logic                         full, empty;
  wb_req_t                      head, push_req;
  logic [DEPTH-1:0]             ent_vld;
  logic [DEPTH-1:0][REG_AW-1:0] ent_rd;
  logic                         hit, alu_take, ld_take, pop;

  logic              rf_we_q, rf_we_d;
  logic [REG_AW-1:0] rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
  logic [NREGS-1:0]  busy;

  // An ALU write to a register with an older queued load must wait for that load.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && (ent_rd[i] == wb.alu_rd) && (wb.alu_rd != '0)) hit = 1'b1;
    end
  end

  assign wb.ld_ready  = !full;
  assign wb.alu_ready = !full && !hit;
  assign alu_take     = wb.alu_valid && wb.alu_ready;
  assign ld_take      = wb.ld_valid && wb.ld_ready;
  assign pop          = !alu_take && !empty;
  assign push_req     = '{rd: wb.ld_rd, data: wb.ld_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_i     (ld_take),
    .push_req_i (push_req),
    .pop_i      (pop),
    .full_o     (full),
    .empty_o    (empty),
    .head_o     (head),
    .ent_vld_o  (ent_vld),
    .ent_rd_o   (ent_rd)
  );

  // x0 results are consumed but never drive the write port; address/data then hold.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    if (alu_take) begin
      if (wb.alu_rd != '0) begin
        rf_we_d    = 1'b1;
        rf_rd_d    = wb.alu_rd;
        rf_wdata_d = wb.alu_data;
      end
    end else if (pop) begin
      if (head.rd != '0) begin
        rf_we_d    = 1'b1;
        rf_rd_d    = head.rd;
        rf_wdata_d = head.data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  always_comb begin
    busy = rf_we_q ? onehot_rd(rf_rd_q) : '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i]) busy = busy | onehot_rd(ent_rd[i]);
    end
  end

  assign wb.rf_we     = rf_we_q;
  assign wb.rf_rd     = rf_rd_q;
  assign wb.rf_wdata  = rf_wdata_q;
  assign wb.busy_mask = busy;
endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: a queue-level reference model predicts handshakes,
// busy mask and the write stream; a negedge monitor checks every write the DUT presents.
module tb_regfile_writeback;
  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ld_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  regfile_writeback_if #(.XLEN(32)) wb ();
  regfile_writeback #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .wb      (wb)
  );

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    alu_stall_seen = 0;
  int    ld_stall_seen = 0;
  ld_t   lq[$];
  exp_t  sb[$];
  logic        m_we = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [31:0] exp_rf [32];
  logic [31:0] dut_rf [32];
  exp_t        mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] m;
    m = '0;
    foreach (lq[i]) if (lq[i].rd != 0) m[lq[i].rd] = 1'b1;
    if (m_we && m_rd != 0) m[m_rd] = 1'b1;
    return m;
  endfunction

  // One cycle: drive at posedge+1, check handshakes against the model, advance the model.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ldata,
                      output logic a_acc, output logic l_acc);
    logic hit, e_ar, e_lr;
    ld_t  r;
    wb.alu_valid = av;  wb.alu_rd = ard;  wb.alu_data = adata;
    wb.ld_valid  = lv;  wb.ld_rd  = lrd;  wb.ld_data  = ldata;
    #1;
    hit = 1'b0;
    foreach (lq[i]) if (ard != 0 && lq[i].rd == ard) hit = 1'b1;
    e_lr = (lq.size() < DEPTH);
    e_ar = e_lr && !hit;
    chk("alu_ready", 32'(wb.alu_ready), 32'(e_ar));
    chk("ld_ready", 32'(wb.ld_ready), 32'(e_lr));
    chk("busy_mask", wb.busy_mask, model_busy());
    if (!e_ar) alu_stall_seen++;
    if (!e_lr) ld_stall_seen++;
    a_acc = av && e_ar;
    l_acc = lv && e_lr;
    m_we = 1'b0;
    if (a_acc) begin
      if (ard != 0) begin
        m_we = 1'b1; m_rd = ard;
        sb.push_back('{rd: ard, data: adata, due: cyc + 1});
      end
    end else if (lq.size() > 0) begin
      r = lq.pop_front();
      if (r.rd != 0) begin
        m_we = 1'b1; m_rd = r.rd;
        sb.push_back('{rd: r.rd, data: r.data, due: cyc + 1});
      end
    end
    if (l_acc) lq.push_back('{rd: lrd, data: ldata});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic a, l;
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, a, l);
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (wb.rf_we) begin
        dut_rf[wb.rf_rd] = wb.rf_wdata;
        if (sb.size() == 0 || sb[0].due != cyc) begin
          checks++; failures++;
          $display("FAIL unexpected_write rd=%0d data=0x%0h (cycle %0d)", wb.rf_rd, wb.rf_wdata, cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("wr_rd", 32'(wb.rf_rd), 32'(mon_e.rd));
          chk("wr_data", wb.rf_wdata, mon_e.data);
          exp_rf[mon_e.rd] = mon_e.data;
        end
      end else if (sb.size() > 0 && sb[0].due == cyc) begin
        mon_e = sb.pop_front();
        checks++; failures++;
        $display("FAIL missing_write actual=none expected rd=%0d data=0x%0h (cycle %0d)",
                 mon_e.rd, mon_e.data, cyc);
        exp_rf[mon_e.rd] = mon_e.data;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic aa, la;
    int   n;
    for (int r = 0; r < 32; r++) begin exp_rf[r] = '0; dut_rf[r] = '0; end
    wb.alu_valid = 1'b0; wb.alu_rd = '0; wb.alu_data = '0;
    wb.ld_valid  = 1'b0; wb.ld_rd  = '0; wb.ld_data  = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rf_we", 32'(wb.rf_we), 32'd0);
    chk("rst_rf_rd", 32'(wb.rf_rd), 32'd0);
    chk("rst_rf_wdata", wb.rf_wdata, 32'd0);
    chk("rst_busy", wb.busy_mask, 32'd0);
    chk("rst_alu_ready", 32'(wb.alu_ready), 32'd1);
    chk("rst_ld_ready", 32'(wb.ld_ready), 32'd1);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // ALU-only stream
    for (int i = 1; i <= 5; i++) step(1'b1, 5'(i), 32'(i * 16), 1'b0, 5'd0, 32'd0, aa, la);
    idle(3);
    chk("alu_x3", dut_rf[3], 32'h30);

    // Queue back-pressure: loads compete with a continuous ALU stream
    alu_stall_seen = 0; ld_stall_seen = 0;
    for (int i = 0; i < 4; i++)
      step(1'b1, 5'd10, 32'hA00 + 32'(i), 1'b1, 5'(6 + i), 32'h600 + 32'(i), aa, la);
    step(1'b1, 5'd10, 32'hA04, 1'b1, 5'd11, 32'h6FF, aa, la);
    chk("bp_ld_blocked_when_full", 32'(la), 32'd0);
    for (int i = 0; i < 8; i++) step(1'b1, 5'd10, 32'hA10 + 32'(i), 1'b0, 5'd0, 32'd0, aa, la);
    idle(6);
    chk("bp_alu_stall_seen", 32'(alu_stall_seen > 0), 32'd1);
    chk("bp_ld_stall_seen", 32'(ld_stall_seen > 0), 32'd1);
    chk("bp_x9", dut_rf[9], 32'h603);

    // WAW hazard between a queued load and a younger ALU write
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAAAA, aa, la);
    n = 0; aa = 1'b0;
    while (!aa && n < 10) begin
      chk("waw_busy7", 32'(wb.busy_mask[7]), 32'd1);
      step(1'b1, 5'd7, 32'h5555, 1'b0, 5'd0, 32'd0, aa, la);
      n++;
    end
    chk("waw_alu_accepted", 32'(aa), 32'd1);
    chk("waw_alu_stalled", 32'(n > 1), 32'd1);
    idle(3);
    chk("waw_x7", dut_rf[7], 32'h5555);

    // x0 from both sources is consumed without a write
    step(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'h1234, aa, la);
    chk("rd0_alu_acc", 32'(aa), 32'd1);
    chk("rd0_ld_acc", 32'(la), 32'd1);
    idle(4);
    chk("rd0_x0", dut_rf[0], 32'd0);

    // Alternating traffic with wrap-around, then fully random traffic
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0)
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'($urandom_range(0, 7)), $urandom, aa, la);
      else
        step(1'b1, 5'($urandom_range(0, 7)), $urandom, 1'b0, 5'd0, 32'd0, aa, la);
    end
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, aa, la);
    idle(8);

    // Mid-stream reset with loads queued drops them all
    step(1'b1, 5'd11, 32'hB11, 1'b1, 5'd13, 32'hD13, aa, la);
    step(1'b1, 5'd12, 32'hB12, 1'b1, 5'd14, 32'hD14, aa, la);
    reset_n = 1'b0;
    lq.delete(); sb.delete(); m_we = 1'b0;
    #2;
    chk("midrst_rf_we", 32'(wb.rf_we), 32'd0);
    chk("midrst_busy", wb.busy_mask, 32'd0);
    chk("midrst_alu_ready", 32'(wb.alu_ready), 32'd1);
    chk("midrst_ld_ready", 32'(wb.ld_ready), 32'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(6);
    chk("midrst_x13_untouched", dut_rf[13], exp_rf[13]);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    for (int r = 0; r < 32; r++) chk($sformatf("final_x%0d", r), dut_rf[r], exp_rf[r]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
